// File: rtl/boid_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : boid_pkg                                                   |
// | Description : Shared screen geometry, coordinate/velocity widths and the |
// |               sweep FSM state encoding for the boid position unit and    |
// |               the VGA controller.                                        |
// | Revision    : 1.0 - initial multi-boid release                           |
// +--------------------------------------------------------------------------+
package boid_pkg;

    // Width of a linear framebuffer address able to hold width*height pixels
    function automatic int boid_address_width(input int width, input int height);
        return $clog2(width * height) + 1;
    endfunction

    localparam int BOID_VIDEO_WIDTH         = 640;
    localparam int BOID_VIDEO_HEIGHT        = 480;
    localparam int BOID_PIXEL_ADDRESS_WIDTH = boid_address_width(BOID_VIDEO_WIDTH, BOID_VIDEO_HEIGHT);

    localparam int BOID_X_WIDTH   = 10;
    localparam int BOID_Y_WIDTH   = 9;
    localparam int BOID_VEL_WIDTH = 4;

    // Sweep FSM encoding
    localparam int         STATE_WIDTH = 2;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_UPDATE    = 2'd1;
    localparam logic [1:0] S_EMIT      = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/boid_position_unit_edge_step.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : boid_edge_step                                             |
// | Description : Combinational one-axis integrate step: pos + vel, then     |
// |               bounce (MODE=0) or wrap (MODE=1) against [0, LIMIT-1].     |
// | Revision    : 1.0 - initial multi-boid release                           |
// +--------------------------------------------------------------------------+
module boid_edge_step #(
    parameter int LIMIT     = 640,
    parameter int POS_WIDTH = 10,
    parameter int VEL_WIDTH = 4,
    parameter int MODE      = 0
) (
    input  logic [POS_WIDTH-1:0] i_pos,
    input  logic [VEL_WIDTH-1:0] i_vel,
    output logic [POS_WIDTH-1:0] o_pos,
    output logic [VEL_WIDTH-1:0] o_vel
);

    // Two guard bits: one for sign, one so the 2*(LIMIT-1) mirror fits
    localparam int SUM_WIDTH = POS_WIDTH + 2;

    localparam logic signed [SUM_WIDTH-1:0] c_limit  = SUM_WIDTH'(LIMIT);
    localparam logic signed [SUM_WIDTH-1:0] c_max    = SUM_WIDTH'(LIMIT - 1);
    localparam logic signed [SUM_WIDTH-1:0] c_mirror = SUM_WIDTH'(2 * (LIMIT - 1));
    localparam logic [VEL_WIDTH-1:0]        c_vel_max = {1'b0, {(VEL_WIDTH-1){1'b1}}};
    localparam logic [VEL_WIDTH-1:0]        c_vel_min = {1'b1, {(VEL_WIDTH-1){1'b0}}};

    logic signed [SUM_WIDTH-1:0] w_sum;
    logic signed [SUM_WIDTH-1:0] w_pos;
    logic [VEL_WIDTH-1:0]        w_vel_neg;
    logic [1:0]                  w_unused_pos_msb;

    assign w_sum = $signed({2'b00, i_pos})
                 + $signed({{(SUM_WIDTH-VEL_WIDTH){i_vel[VEL_WIDTH-1]}}, i_vel});

    // The most negative velocity has no positive twin; clamp it to the largest one
    assign w_vel_neg = (i_vel == c_vel_min) ? c_vel_max : (~i_vel + 1'b1);

    // Edge handling; |vel| is tiny versus LIMIT so one correction is enough
    always_comb begin
        w_pos = w_sum;
        o_vel = i_vel;
        if (MODE == 0) begin
            if (w_sum < 0) begin
                w_pos = -w_sum;
                o_vel = w_vel_neg;
            end else if (w_sum > c_max) begin
                w_pos = c_mirror - w_sum;
                o_vel = w_vel_neg;
            end
        end else begin
            if (w_sum < 0) begin
                w_pos = w_sum + c_limit;
            end else if (w_sum > c_max) begin
                w_pos = w_sum - c_limit;
            end
        end
    end

    assign o_pos            = w_pos[POS_WIDTH-1:0];
    assign w_unused_pos_msb = w_pos[SUM_WIDTH-1:POS_WIDTH];

endmodule
`default_nettype wire

// File: rtl/boid_position_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : boid_position_unit                                         |
// | Description : Holds position/velocity for NUM_BOIDS boids. Each frame    |
// |               tick sweeps all boids in order, integrates velocity with   |
// |               bounce or wrap edges, and streams (id, x, y, address).     |
// | Revision    : 1.0 - initial multi-boid release                           |
// +--------------------------------------------------------------------------+
module boid_position_unit
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS           = 8,
    parameter int VIDEO_WIDTH         = BOID_VIDEO_WIDTH,
    parameter int VIDEO_HEIGHT        = BOID_VIDEO_HEIGHT,
    parameter int VEL_WIDTH           = BOID_VEL_WIDTH,
    parameter int EDGE_MODE           = 0,
    parameter int PIXEL_ADDRESS_WIDTH = boid_address_width(VIDEO_WIDTH, VIDEO_HEIGHT),
    localparam int ID_WIDTH           = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           frame_tick,
    input  logic                           cfg_we,
    input  logic [ID_WIDTH-1:0]            cfg_id,
    input  logic [VEL_WIDTH-1:0]           cfg_vx,
    input  logic [VEL_WIDTH-1:0]           cfg_vy,
    output logic                           busy,
    output logic                           done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic [BOID_X_WIDTH-1:0]        out_x,
    output logic [BOID_Y_WIDTH-1:0]        out_y,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] out_address
);

    localparam logic [ID_WIDTH-1:0]  c_last_index = ID_WIDTH'(NUM_BOIDS - 1);
    localparam logic [VEL_WIDTH-1:0] c_vel_one    = VEL_WIDTH'(1);

    logic [BOID_X_WIDTH-1:0] r_pos_x [NUM_BOIDS];
    logic [BOID_Y_WIDTH-1:0] r_pos_y [NUM_BOIDS];
    logic [VEL_WIDTH-1:0]    r_vel_x [NUM_BOIDS];
    logic [VEL_WIDTH-1:0]    r_vel_y [NUM_BOIDS];

    logic [STATE_WIDTH-1:0]         r_state;
    logic [ID_WIDTH-1:0]            r_index;
    logic [ID_WIDTH-1:0]            r_out_id;
    logic [BOID_X_WIDTH-1:0]        r_out_x;
    logic [BOID_Y_WIDTH-1:0]        r_out_y;
    logic [PIXEL_ADDRESS_WIDTH-1:0] r_out_address;

    logic [BOID_X_WIDTH-1:0]        w_new_x;
    logic [BOID_Y_WIDTH-1:0]        w_new_y;
    logic [VEL_WIDTH-1:0]           w_new_vx;
    logic [VEL_WIDTH-1:0]           w_new_vy;
    logic [PIXEL_ADDRESS_WIDTH-1:0] w_address;
    logic                           w_cfg_in_range;

    boid_edge_step #(
        .LIMIT     (VIDEO_WIDTH),
        .POS_WIDTH (BOID_X_WIDTH),
        .VEL_WIDTH (VEL_WIDTH),
        .MODE      (EDGE_MODE)
    ) u_step_x (
        .i_pos (r_pos_x[r_index]),
        .i_vel (r_vel_x[r_index]),
        .o_pos (w_new_x),
        .o_vel (w_new_vx)
    );

    boid_edge_step #(
        .LIMIT     (VIDEO_HEIGHT),
        .POS_WIDTH (BOID_Y_WIDTH),
        .VEL_WIDTH (VEL_WIDTH),
        .MODE      (EDGE_MODE)
    ) u_step_y (
        .i_pos (r_pos_y[r_index]),
        .i_vel (r_vel_y[r_index]),
        .o_pos (w_new_y),
        .o_vel (w_new_vy)
    );

    // Linear address of the freshly integrated position
    generate
        if (VIDEO_WIDTH == 640) begin : g_addr_shift
            assign w_address = (PIXEL_ADDRESS_WIDTH'(w_new_y) << 9)
                             + (PIXEL_ADDRESS_WIDTH'(w_new_y) << 7)
                             + PIXEL_ADDRESS_WIDTH'(w_new_x);
        end else begin : g_addr_mult
            assign w_address = PIXEL_ADDRESS_WIDTH'(w_new_x)
                             + PIXEL_ADDRESS_WIDTH'(w_new_y) * PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH);
        end
    endgenerate

    // Protects against ids past the last boid when NUM_BOIDS is not a power of two
    assign w_cfg_in_range = (32'(cfg_id) < NUM_BOIDS);

    // Sweep FSM plus boid state; velocity writes land only while idle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_out_id      <= '0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_out_address <= '0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                r_pos_x[i] <= BOID_X_WIDTH'((64 * i + 32) % VIDEO_WIDTH);
                r_pos_y[i] <= BOID_Y_WIDTH'((48 * i + 24) % VIDEO_HEIGHT);
                r_vel_x[i] <= c_vel_one;
                r_vel_y[i] <= c_vel_one;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_we && w_cfg_in_range) begin
                        r_vel_x[cfg_id] <= cfg_vx;
                        r_vel_y[cfg_id] <= cfg_vy;
                    end
                    if (frame_tick) begin
                        r_index <= '0;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_pos_x[r_index] <= w_new_x;
                    r_pos_y[r_index] <= w_new_y;
                    r_vel_x[r_index] <= w_new_vx;
                    r_vel_y[r_index] <= w_new_vy;
                    r_out_id         <= r_index;
                    r_out_x          <= w_new_x;
                    r_out_y          <= w_new_y;
                    r_out_address    <= w_address;
                    r_state          <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_index == c_last_index) begin
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_UPDATE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign out_valid   = (r_state == S_EMIT);
    assign out_id      = r_out_id;
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign out_address = r_out_address;

endmodule
`default_nettype wire

// File: tb/tb_boid_position_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_boid_position_unit                                      |
// | Description : Directed bench driving a bounce and a wrap instance with   |
// |               the same stimulus; expected values are hand-computed.      |
// | Revision    : 1.0 - initial multi-boid release                           |
// +--------------------------------------------------------------------------+
module tb_boid_position_unit;
    import boid_pkg::*;

    localparam int N = 8;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b0;
    logic       frame_tick = 1'b0;
    logic       cfg_we     = 1'b0;
    logic [2:0] cfg_id     = 3'd0;
    logic [3:0] cfg_vx     = 4'd0;
    logic [3:0] cfg_vy     = 4'd0;
    logic       out_ready  = 1'b1;

    logic        busy_b, done_b, valid_b, busy_w, done_w, valid_w;
    logic [2:0]  id_b, id_w;
    logic [9:0]  x_b, x_w;
    logic [8:0]  y_b, y_w;
    logic [BOID_PIXEL_ADDRESS_WIDTH-1:0] a_b, a_w;

    logic [9:0]  cap_x_b [N];
    logic [8:0]  cap_y_b [N];
    logic [19:0] cap_a_b [N];
    logic [9:0]  cap_x_w [N];
    logic [8:0]  cap_y_w [N];
    logic [19:0] cap_a_w [N];

    int errors = 0;
    int checks = 0;
    int sw_cycles;
    bit sw_order_ok, sw_stable, sw_done_seen;

    boid_position_unit #(.NUM_BOIDS(N), .EDGE_MODE(0)) u_dut_bounce (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_id(id_b), .out_x(x_b), .out_y(y_b), .out_address(a_b)
    );

    boid_position_unit #(.NUM_BOIDS(N), .EDGE_MODE(1)) u_dut_wrap (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
        .busy(busy_w), .done(done_w), .out_valid(valid_w), .out_ready(out_ready),
        .out_id(id_w), .out_x(x_w), .out_y(y_w), .out_address(a_w)
    );

    always #10 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        resetn     = 1'b0;
        frame_tick = 1'b0;
        cfg_we     = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // One sweep with optional cfg on the tick cycle, optional stall and optional mid-sweep injection
    task automatic run_sweep(input bit with_cfg, input logic [2:0] id, input logic [3:0] vx,
                             input logic [3:0] vy, input int stall_id, input int stall_n,
                             input int inject_at);
        int         next_id;
        int         stalls_left;
        bit         have_snap;
        logic [9:0] sx;
        logic [8:0] sy;
        logic [19:0] sa;
        next_id      = 0;
        stalls_left  = stall_n;
        have_snap    = 1'b0;
        sx = '0; sy = '0; sa = '0;
        sw_cycles    = 0;
        sw_order_ok  = 1'b1;
        sw_stable    = 1'b1;
        sw_done_seen = 1'b0;
        @(negedge clock);
        frame_tick = 1'b1;
        if (with_cfg) begin
            cfg_we = 1'b1; cfg_id = id; cfg_vx = vx; cfg_vy = vy;
        end
        @(negedge clock);
        for (int k = 0; k < 400; k++) begin
            frame_tick = 1'b0;
            cfg_we     = 1'b0;
            if (done_b) begin
                sw_done_seen = 1'b1;
                break;
            end
            if (busy_b) sw_cycles++;
            if (k == inject_at) begin
                frame_tick = 1'b1; cfg_we = 1'b1; cfg_id = 3'd0; cfg_vx = 4'd7; cfg_vy = 4'd7;
            end
            if (valid_b && int'(id_b) == stall_id && stalls_left > 0) begin
                out_ready = 1'b0;
                stalls_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (valid_b && int'(id_b) == stall_id) begin
                if (!have_snap) begin
                    sx = x_b; sy = y_b; sa = a_b; have_snap = 1'b1;
                end else if (x_b !== sx || y_b !== sy || a_b !== sa) begin
                    sw_stable = 1'b0;
                end
            end
            if (valid_b && out_ready) begin
                if (int'(id_b) != next_id) sw_order_ok = 1'b0;
                cap_x_b[id_b] = x_b; cap_y_b[id_b] = y_b; cap_a_b[id_b] = a_b;
                cap_x_w[id_w] = x_w; cap_y_w[id_w] = y_w; cap_a_w[id_w] = a_w;
                next_id++;
            end
            @(negedge clock);
        end
        frame_tick = 1'b0;
        cfg_we     = 1'b0;
        out_ready  = 1'b1;
        if (next_id != N) sw_order_ok = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_b); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_b); end
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_b); end
        checks++; if (id_b !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", id_b); end
        checks++; if (x_b !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", x_b); end
        checks++; if (y_b !== 9'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y_b); end
        checks++; if (a_b !== 20'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", a_b); end
        checks++; if ({valid_w, busy_w, done_w} !== 3'b000) begin errors++; $display("FAIL reset_wrap_flags: got %b want 000", {valid_w, busy_w, done_w}); end
        checks++; if ({id_w, x_w, y_w, a_w} !== '0) begin errors++; $display("FAIL reset_wrap_outs: got id=%0d x=%0d y=%0d a=%0d want 0", id_w, x_w, y_w, a_w); end
    endtask

    task automatic test_first_sweep();
        apply_reset();
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        checks++; if (!sw_done_seen) begin errors++; $display("FAIL first_done: done not seen within budget"); end
        checks++; if (sw_cycles !== 16) begin errors++; $display("FAIL first_cycles: got %0d want 16", sw_cycles); end
        checks++; if (!sw_order_ok) begin errors++; $display("FAIL first_order: ids not 0..7 in order"); end
        for (int i = 0; i < N; i++) begin
            checks++; if (int'(cap_x_b[i]) !== 64*i + 33) begin errors++; $display("FAIL first_x[%0d]: got %0d want %0d", i, cap_x_b[i], 64*i + 33); end
            checks++; if (int'(cap_y_b[i]) !== 48*i + 25) begin errors++; $display("FAIL first_y[%0d]: got %0d want %0d", i, cap_y_b[i], 48*i + 25); end
            checks++; if (int'(cap_a_b[i]) !== (64*i + 33) + 640*(48*i + 25)) begin errors++; $display("FAIL first_addr[%0d]: got %0d want %0d", i, cap_a_b[i], (64*i + 33) + 640*(48*i + 25)); end
        end
        checks++; if (cap_a_b[0] !== 20'd16033) begin errors++; $display("FAIL first_addr0: got %0d want 16033", cap_a_b[0]); end
        @(negedge clock);
        checks++; if ({busy_b, done_b} !== 2'b00) begin errors++; $display("FAIL first_after_done: busy/done=%b want 00", {busy_b, done_b}); end
    endtask

    task automatic test_bounce();
        apply_reset();
        run_sweep(1'b1, 3'd2, 4'd7, 4'd1, -1, 0, -1);
        checks++; if (cap_x_b[2] !== 10'd167) begin errors++; $display("FAIL bounce_same_cycle_cfg: got x=%0d want 167", cap_x_b[2]); end
        for (int s = 0; s < 67; s++) run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        checks++; if (cap_x_b[2] !== 10'd636 || cap_y_b[2] !== 9'd188) begin errors++; $display("FAIL bounce_pre: got (%0d,%0d) want (636,188)", cap_x_b[2], cap_y_b[2]); end
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        checks++; if (cap_x_b[2] !== 10'd635) begin errors++; $display("FAIL bounce_edge: got x=%0d want 635", cap_x_b[2]); end
        checks++; if (cap_a_b[2] !== 20'd121595) begin errors++; $display("FAIL bounce_edge_addr: got %0d want 121595", cap_a_b[2]); end
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        checks++; if (cap_x_b[2] !== 10'd628 || cap_y_b[2] !== 9'd190) begin errors++; $display("FAIL bounce_after: got (%0d,%0d) want (628,190)", cap_x_b[2], cap_y_b[2]); end
    endtask

    task automatic test_wrap();
        apply_reset();
        run_sweep(1'b1, 3'd0, 4'hB, 4'hC, -1, 0, -1);
        for (int s = 0; s < 4; s++) run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        run_sweep(1'b1, 3'd0, 4'hB, 4'hA, -1, 0, -1);
        checks++; if (cap_x_w[0] !== 10'd2 || cap_y_w[0] !== 9'd478) begin errors++; $display("FAIL wrap_y_low: got (%0d,%0d) want (2,478)", cap_x_w[0], cap_y_w[0]); end
        checks++; if (cap_a_w[0] !== 20'd305922) begin errors++; $display("FAIL wrap_y_low_addr: got %0d want 305922", cap_a_w[0]); end
        checks++; if (cap_x_b[0] !== 10'd2 || cap_y_b[0] !== 9'd2) begin errors++; $display("FAIL bounce_y_low: got (%0d,%0d) want (2,2)", cap_x_b[0], cap_y_b[0]); end
        run_sweep(1'b1, 3'd0, 4'hB, 4'h3, -1, 0, -1);
        checks++; if (cap_x_w[0] !== 10'd637 || cap_y_w[0] !== 9'd1) begin errors++; $display("FAIL wrap_edges: got (%0d,%0d) want (637,1)", cap_x_w[0], cap_y_w[0]); end
        checks++; if (cap_a_w[0] !== 20'd1277) begin errors++; $display("FAIL wrap_addr: got %0d want 1277", cap_a_w[0]); end
        checks++; if (cap_x_b[0] !== 10'd3 || cap_y_b[0] !== 9'd5) begin errors++; $display("FAIL bounce_x_low: got (%0d,%0d) want (3,5)", cap_x_b[0], cap_y_b[0]); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, 3, 5, -1);
        checks++; if (!sw_done_seen) begin errors++; $display("FAIL bp_done: done not seen within budget"); end
        checks++; if (sw_cycles !== 21) begin errors++; $display("FAIL bp_cycles: got %0d want 21", sw_cycles); end
        checks++; if (!sw_stable) begin errors++; $display("FAIL bp_stable: outputs changed while stalled"); end
        checks++; if (!sw_order_ok) begin errors++; $display("FAIL bp_order: ids not 0..7 in order"); end
        checks++; if (cap_x_b[3] !== 10'd225 || cap_y_b[3] !== 9'd169) begin errors++; $display("FAIL bp_boid3: got (%0d,%0d) want (225,169)", cap_x_b[3], cap_y_b[3]); end
        checks++; if (cap_x_b[4] !== 10'd289 || cap_y_b[4] !== 9'd217) begin errors++; $display("FAIL bp_boid4: got (%0d,%0d) want (289,217)", cap_x_b[4], cap_y_b[4]); end
    endtask

    task automatic test_busy_ignore();
        bit stray_busy;
        apply_reset();
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, 5);
        checks++; if (sw_cycles !== 16) begin errors++; $display("FAIL ignore_cycles: got %0d want 16", sw_cycles); end
        checks++; if (cap_x_b[0] !== 10'd33 || cap_y_b[0] !== 9'd25) begin errors++; $display("FAIL ignore_first: got (%0d,%0d) want (33,25)", cap_x_b[0], cap_y_b[0]); end
        stray_busy = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (busy_b) stray_busy = 1'b1;
        end
        checks++; if (stray_busy) begin errors++; $display("FAIL ignore_tick: busy=1 want 0 after sweep (tick was queued)"); end
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        checks++; if (cap_x_b[0] !== 10'd34 || cap_y_b[0] !== 9'd26) begin errors++; $display("FAIL ignore_cfg: got (%0d,%0d) want (34,26)", cap_x_b[0], cap_y_b[0]); end
        checks++; if (cap_x_b[7] !== 10'd482 || cap_y_b[7] !== 9'd362) begin errors++; $display("FAIL ignore_boid7: got (%0d,%0d) want (482,362)", cap_x_b[7], cap_y_b[7]); end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        apply_reset();
        @(negedge clock);
        frame_tick = 1'b1; cfg_we = 1'b1; cfg_id = 3'd0; cfg_vx = 4'd3; cfg_vy = 4'd3;
        @(negedge clock);
        frame_tick = 1'b0; cfg_we = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (valid_b && id_b == 3'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checks++; if (!found) begin errors++; $display("FAIL midreset_reach: boid 5 EMIT not seen within budget"); end
        resetn = 1'b0;
        @(negedge clock);
        checks++; if ({valid_b, busy_b} !== 2'b00) begin errors++; $display("FAIL midreset_flags: valid/busy=%b want 00", {valid_b, busy_b}); end
        checks++; if ({valid_w, busy_w} !== 2'b00) begin errors++; $display("FAIL midreset_wrap_flags: valid/busy=%b want 00", {valid_w, busy_w}); end
        resetn = 1'b1;
        run_sweep(1'b0, 3'd0, 4'd0, 4'd0, -1, 0, -1);
        checks++; if (cap_x_b[0] !== 10'd33 || cap_y_b[0] !== 9'd25) begin errors++; $display("FAIL midreset_boid0: got (%0d,%0d) want (33,25)", cap_x_b[0], cap_y_b[0]); end
        checks++; if (sw_cycles !== 16) begin errors++; $display("FAIL midreset_cycles: got %0d want 16", sw_cycles); end
    endtask

    initial begin
        test_reset();
        test_first_sweep();
        test_bounce();
        test_wrap();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
